multicycle_control: RTL and testbench

- Main sequencing FSM for the multicycle MIPS datapath.
- Consumes opcode/func from the instruction register plus the ULA zero flag and a memory handshake.
- Drives all datapath enables and muxes, and produces the 4-bit ula_operation code consumed by the ULA control decoder.
- One instruction in flight; 3–5 cycles per instruction plus memory wait states.

---
 rtl/multicycle_control.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle MIPS datapath.
// One instruction in flight: FETCH -> DECODE -> class-specific states -> FETCH.
// Datapath controls are decoded from the registered state. The only
// exceptions are the FETCH-cycle PC/IR loads, which wait for mem_ready, and
// a few controls that also look at the opcode.
module multicycle_control #(
  parameter int STATE_W = 4  // exported state width, must be at least 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               ula_src_a,
  output logic [1:0]         ula_src_b,
  output logic               imm_zero_ext,
  output logic [3:0]         ula_operation,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  // Fixed encoding: the state value is exported for debug and verification.
  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11,
    S_I_EXEC   = 4'd12,
    S_I_WB     = 4'd13,
    S_TRAP     = 4'd14,
    S_UNUSED   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t      r_state;
  state_t      w_decode_target;
  logic        w_r_supported;
  logic [3:0]  w_i_ula_op;
  logic        w_i_zero_ext;
  // The zero flag is consumed by the datapath's branch gate, not by this FSM.
  logic        w_zero_unused;

  assign w_zero_unused = zero;
  assign state         = STATE_W'(r_state);

  // Supported R-type function codes; anything else traps.
  always_comb begin
    w_r_supported = 1'b0;
    case (func)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
      6'b101010, 6'b101011: w_r_supported = 1'b1;
      default:              w_r_supported = 1'b0;
    endcase
  end

  // Where DECODE goes next, chosen by the instruction class.
  always_comb begin
    w_decode_target = S_TRAP;
    if (opcode == OP_LW || opcode == OP_SW) begin
      w_decode_target = S_MEM_ADDR;
    end else if (opcode == OP_RTYPE) begin
      if (func == FN_JR) begin
        w_decode_target = S_JR;
      end else if (w_r_supported) begin
        w_decode_target = S_R_EXEC;
      end else begin
        w_decode_target = S_TRAP;
      end
    end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
      w_decode_target = S_BRANCH;
    end else if (opcode == OP_J) begin
      w_decode_target = S_JUMP;
    end else if (opcode[5:3] == 3'b001) begin
      w_decode_target = S_I_EXEC;
    end
  end

  // Immediate-class ULA code and extender mode, keyed on the low opcode bits.
  always_comb begin
    w_i_ula_op   = 4'b0000;
    w_i_zero_ext = 1'b0;
    case (opcode[2:0])
      3'b000, 3'b001: w_i_ula_op = 4'b0000;  // addi / addiu
      3'b010:         w_i_ula_op = 4'b0011;  // slti
      3'b011:         w_i_ula_op = 4'b1000;  // sltiu
      3'b100: begin w_i_ula_op = 4'b0100; w_i_zero_ext = 1'b1; end  // andi
      3'b101: begin w_i_ula_op = 4'b0101; w_i_zero_ext = 1'b1; end  // ori
      3'b110: begin w_i_ula_op = 4'b0110; w_i_zero_ext = 1'b1; end  // xori
      default:        w_i_ula_op = 4'b0111;  // lui
    endcase
  end

  // State register and transitions; TRAP holds until reset, encoding 15 recovers via RST.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_RST;
    end else begin
      case (r_state)
        S_RST:      r_state <= S_FETCH;
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= w_decode_target;
        S_MEM_ADDR: r_state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WB:   r_state <= S_FETCH;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:   r_state <= S_R_WB;
        S_R_WB:     r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        S_JR:       r_state <= S_FETCH;
        S_I_EXEC:   r_state <= S_I_WB;
        S_I_WB:     r_state <= S_FETCH;
        S_TRAP:     r_state <= S_TRAP;
        default:    r_state <= S_RST;
      endcase
    end
  end

  // Datapath controls decoded from the current state; anything not set is 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    ula_src_a     = 1'b0;
    ula_src_b     = 2'b00;
    imm_zero_ext  = 1'b0;
    ula_operation = 4'b0000;
    illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ula_src_b = 2'b01;
        ir_write  = mem_ready;  // PC+4 and IR commit only when the read lands
        pc_write  = mem_ready;
      end
      S_DECODE:   ula_src_b = 2'b11;  // branch target precomputed into ULA-out
      S_MEM_ADDR: begin
        ula_src_a = 1'b1;
        ula_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ula_src_a     = 1'b1;
        ula_operation = 4'b0010;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ula_src_a     = 1'b1;
        ula_operation = 4'b0001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      S_I_EXEC: begin
        ula_src_a     = 1'b1;
        ula_src_b     = 2'b10;
        ula_operation = w_i_ula_op;
        imm_zero_ext  = w_i_zero_ext;
      end
      S_I_WB:  reg_write = 1'b1;
      S_TRAP:  illegal   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model plus
// directed checks of the listed scenarios and randomized instruction streams.
module tb_multicycle_control;

  localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_RD = 4;
  localparam int S_MEM_WB = 5, S_MEM_WR = 6, S_R_EXEC = 7, S_R_WB = 8, S_BRANCH = 9;
  localparam int S_JUMP = 10, S_JR = 11, S_I_EXEC = 12, S_I_WB = 13, S_TRAP = 14;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, ula_src_a, imm_zero_ext, illegal;
  logic [1:0] pc_source, ula_src_b;
  logic [3:0] ula_operation;
  logic [3:0] state;
  logic [20:0] dut_out;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clock(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .ula_src_a(ula_src_a), .ula_src_b(ula_src_b),
    .imm_zero_ext(imm_zero_ext), .ula_operation(ula_operation), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  assign dut_out = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
                    ir_write, reg_dst, mem_to_reg, reg_write, ula_src_a, ula_src_b,
                    imm_zero_ext, ula_operation, illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  int  exp_state   = S_RST;
  bit  model_valid = 1'b0;
  int  path[$];

  // States an instruction walks through after FETCH completes.
  function automatic void load_path(input logic [5:0] op, input logic [5:0] fn);
    path.delete();
    path.push_back(S_DECODE);
    if (op == 6'b100011) begin
      path.push_back(S_MEM_ADDR); path.push_back(S_MEM_RD); path.push_back(S_MEM_WB);
    end else if (op == 6'b101011) begin
      path.push_back(S_MEM_ADDR); path.push_back(S_MEM_WR);
    end else if (op == 6'b000000) begin
      if (fn == 6'b001000) path.push_back(S_JR);
      else if (fn inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                          6'b100000, 6'b100010, [6'b100100:6'b100111], 6'b101010, 6'b101011}) begin
        path.push_back(S_R_EXEC); path.push_back(S_R_WB);
      end else path.push_back(S_TRAP);
    end else if (op == 6'b000100 || op == 6'b000101) path.push_back(S_BRANCH);
    else if (op == 6'b000010) path.push_back(S_JUMP);
    else if (op >= 6'b001000 && op <= 6'b001111) begin
      path.push_back(S_I_EXEC); path.push_back(S_I_WB);
    end else path.push_back(S_TRAP);
  endfunction

  function automatic logic [20:0] exp_out(input int st, input logic [5:0] op, input logic mr);
    logic pcw, pwc, bne, iord, mrd, mwr, irw, rdst, mtr, rw, srca, ize, ill;
    logic [1:0] psrc, srcb;
    logic [3:0] uop;
    {pcw, pwc, bne, iord, mrd, mwr, irw, rdst, mtr, rw, srca, ize, ill} = '0;
    psrc = 2'b00; srcb = 2'b00; uop = 4'b0000;
    case (st)
      S_FETCH:    begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:   srcb = 2'b11;
      S_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; mtr = 1; end
      S_MEM_WR:   begin mwr = 1; iord = 1; end
      S_R_EXEC:   begin srca = 1; uop = 4'b0010; end
      S_R_WB:     begin rw = 1; rdst = 1; end
      S_BRANCH:   begin srca = 1; uop = 4'b0001; pwc = 1; psrc = 2'b01; bne = (op == 6'b000101); end
      S_JUMP:     begin pcw = 1; psrc = 2'b10; end
      S_JR:       begin pcw = 1; psrc = 2'b11; end
      S_I_EXEC: begin
        srca = 1; srcb = 2'b10;
        case (op)
          6'b001010: uop = 4'b0011;
          6'b001011: uop = 4'b1000;
          6'b001100: begin uop = 4'b0100; ize = 1; end
          6'b001101: begin uop = 4'b0101; ize = 1; end
          6'b001110: begin uop = 4'b0110; ize = 1; end
          6'b001111: uop = 4'b0111;
          default:   uop = 4'b0000;
        endcase
      end
      S_I_WB:     rw = 1;
      S_TRAP:     ill = 1;
      default:    ;
    endcase
    return {pcw, pwc, bne, psrc, iord, mrd, mwr, irw, rdst, mtr, rw, srca, srcb, ize, uop, ill};
  endfunction

  // Advance the model on each rising edge using the inputs held across that edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_state = S_RST; path.delete(); model_valid = 1'b1;
      end else if (model_valid) begin
        if (exp_state == S_RST) exp_state = S_FETCH;
        else if (exp_state == S_TRAP) exp_state = S_TRAP;
        else if ((exp_state == S_FETCH || exp_state == S_MEM_RD || exp_state == S_MEM_WR) && !mem_ready)
          exp_state = exp_state;
        else if (exp_state == S_FETCH) begin
          load_path(opcode, func); exp_state = path.pop_front();
        end else if (path.size() == 0) exp_state = S_FETCH;
        else exp_state = path.pop_front();
      end
    end
  end

  // Per-cycle comparison against the model plus the two exclusivity rules.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("state", 32'(state), 32'(exp_state));
        chk("outputs", 32'(dut_out), 32'(exp_out(exp_state, opcode, mem_ready)));
        chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        chk("rw_pcw_excl", 32'(reg_write & pc_write), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] seen_uop [16];
  logic [1:0] seen_psrc[16];
  logic       seen_bne [16];
  logic       seen_pwc [16];
  logic       seen_pcw [16];
  logic       seen_rw  [16];
  logic       seen_rd  [16];
  logic       seen_mtr [16];
  logic       seen_ize [16];

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Run one instruction starting in FETCH; returns cycles spent and a state trace.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                           output int cycles, output int pcw_n, output int irw_n,
                           output logic [31:0] trace);
    int fw_left, mw_left;
    bit left, done;
    fw_left = fw; mw_left = mw; left = 0; done = 0;
    cycles = 0; pcw_n = 0; irw_n = 0; trace = '0;
    for (int s = 0; s < 16; s++) begin
      seen_uop[s] = '0; seen_psrc[s] = '0; seen_bne[s] = 0; seen_pwc[s] = 0; seen_pcw[s] = 0;
      seen_rw[s] = 0; seen_rd[s] = 0; seen_mtr[s] = 0; seen_ize[s] = 0;
    end
    for (int k = 0; k < 60 && !done; k++) begin
      opcode = op; func = fn; zero = 1'($urandom);
      if (exp_state == S_FETCH && fw_left > 0) begin mem_ready = 0; fw_left--; end
      else if ((exp_state == S_MEM_RD || exp_state == S_MEM_WR) && mw_left > 0) begin
        mem_ready = 0; mw_left--;
      end else if (exp_state == S_FETCH || exp_state == S_MEM_RD || exp_state == S_MEM_WR)
        mem_ready = 1;
      else mem_ready = 1'($urandom);
      @(negedge clk);
      cycles++;
      pcw_n += int'(pc_write);
      irw_n += int'(ir_write);
      trace = {trace[27:0], state};
      seen_uop[state] = ula_operation; seen_psrc[state] = pc_source; seen_bne[state] = branch_ne;
      seen_pwc[state] = pc_write_cond; seen_pcw[state] = pc_write; seen_rw[state] = reg_write;
      seen_rd[state] = reg_dst; seen_mtr[state] = mem_to_reg; seen_ize[state] = imm_zero_ext;
      if (state != 4'(S_FETCH)) left = 1;
      next_cycle();
      if (left && state == 4'(S_FETCH)) done = 1;
    end
    trace = {trace[27:0], state};
    if (!done) begin
      checks++; errors++;
      $display("FAIL instr_timeout: op=%b fn=%b did not return to FETCH, state=%0d", op, fn, state);
    end
  endtask

  logic [5:0] rfuncs[13] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                             6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                             6'b101010};

  initial begin
    int cyc, pcw_n, irw_n, illegal_cnt, fw, mw, base, cls;
    logic [31:0] tr;
    logic [5:0] op, fn;

    reset = 1; opcode = '0; func = '0; zero = 0; mem_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(dut_out), 32'd0);
    next_cycle(); reset = 0;
    next_cycle();
    @(negedge clk);
    chk("post_reset_state", 32'(state), 32'd1);
    chk("post_reset_mem_read", 32'(mem_read), 32'd1);
    next_cycle();
    $display("reset released, fetching");

    // lw, no waits
    run_instr(6'b100011, 6'b000000, 0, 0, cyc, pcw_n, irw_n, tr);
    chk("lw_cycles", 32'(cyc), 32'd5);
    chk("lw_trace", tr, 32'h00123451);
    chk("lw_wb_reg_write", 32'(seen_rw[S_MEM_WB]), 32'd1);
    chk("lw_wb_mem_to_reg", 32'(seen_mtr[S_MEM_WB]), 32'd1);
    chk("lw_wb_reg_dst", 32'(seen_rd[S_MEM_WB]), 32'd0);
    $display("lw no-wait: cycles=%0d trace=%h", cyc, tr);

    // lw, 3 fetch waits and 2 read waits
    run_instr(6'b100011, 6'b000000, 3, 2, cyc, pcw_n, irw_n, tr);
    chk("lw_wait_cycles", 32'(cyc), 32'd10);
    chk("lw_wait_pc_write_pulses", 32'(pcw_n), 32'd1);
    chk("lw_wait_ir_write_pulses", 32'(irw_n), 32'd1);
    $display("lw waits: cycles=%0d pc_write=%0d ir_write=%0d", cyc, pcw_n, irw_n);

    // reset in the middle of a stalled MEM_RD
    opcode = 6'b100011; func = '0;
    for (int k = 0; k < 10 && exp_state != S_MEM_RD; k++) begin
      mem_ready = 1; next_cycle();
    end
    mem_ready = 0; reset = 1;
    @(negedge clk);
    chk("pre_reset_in_mem_rd", 32'(state), 32'(S_MEM_RD));
    next_cycle();
    @(negedge clk);
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_outputs", 32'(dut_out), 32'd0);
    next_cycle(); reset = 0;
    @(negedge clk);
    chk("midreset_state2", 32'(state), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("midreset_release_state", 32'(state), 32'd1);
    chk("midreset_release_mem_read", 32'(mem_read), 32'd1);
    next_cycle();
    $display("reset during MEM_RD recovered to FETCH");

    // R-type sub
    run_instr(6'b000000, 6'b100010, 0, 0, cyc, pcw_n, irw_n, tr);
    chk("sub_ula_op", 32'(seen_uop[S_R_EXEC]), 32'h2);
    chk("sub_reg_write", 32'(seen_rw[S_R_WB]), 32'd1);
    chk("sub_reg_dst", 32'(seen_rd[S_R_WB]), 32'd1);
    chk("sub_cycles", 32'(cyc), 32'd4);
    $display("sub: cycles=%0d trace=%h", cyc, tr);

    // jr
    run_instr(6'b000000, 6'b001000, 0, 0, cyc, pcw_n, irw_n, tr);
    chk("jr_trace", tr, 32'h000012B1);
    chk("jr_pc_write", 32'(seen_pcw[S_JR]), 32'd1);
    chk("jr_pc_source", 32'(seen_psrc[S_JR]), 32'd3);
    $display("jr: cycles=%0d trace=%h", cyc, tr);

    // bne / beq
    run_instr(6'b000101, 6'b000000, 0, 0, cyc, pcw_n, irw_n, tr);
    chk("bne_pc_write_cond", 32'(seen_pwc[S_BRANCH]), 32'd1);
    chk("bne_branch_ne", 32'(seen_bne[S_BRANCH]), 32'd1);
    chk("bne_ula_op", 32'(seen_uop[S_BRANCH]), 32'h1);
    chk("bne_cycles", 32'(cyc), 32'd3);
    $display("bne: cycles=%0d trace=%h", cyc, tr);
    run_instr(6'b000100, 6'b000000, 0, 0, cyc, pcw_n, irw_n, tr);
    chk("beq_branch_ne", 32'(seen_bne[S_BRANCH]), 32'd0);
    chk("beq_cycles", 32'(cyc), 32'd3);
    $display("beq: cycles=%0d trace=%h", cyc, tr);

    // ori / lui
    run_instr(6'b001101, 6'b000000, 0, 0, cyc, pcw_n, irw_n, tr);
    chk("ori_ula_op", 32'(seen_uop[S_I_EXEC]), 32'h5);
    chk("ori_zero_ext", 32'(seen_ize[S_I_EXEC]), 32'd1);
    $display("ori: cycles=%0d trace=%h", cyc, tr);
    run_instr(6'b001111, 6'b000000, 0, 0, cyc, pcw_n, irw_n, tr);
    chk("lui_ula_op", 32'(seen_uop[S_I_EXEC]), 32'h7);
    chk("lui_zero_ext", 32'(seen_ize[S_I_EXEC]), 32'd0);
    $display("lui: cycles=%0d trace=%h", cyc, tr);

    // randomized legal instruction stream with random wait states
    for (int n = 0; n < 120; n++) begin
      cls = int'($urandom_range(0, 7));
      fn = 6'($urandom);
      fw = int'($urandom_range(0, 2));
      mw = int'($urandom_range(0, 2));
      case (cls)
        0: begin op = 6'b100011; base = 5 + mw; end
        1: begin op = 6'b101011; base = 4 + mw; end
        2: begin op = 6'b000000; fn = rfuncs[$urandom_range(0, 12)]; base = 4; end
        3: begin op = 6'b000000; fn = 6'b001000; base = 3; end
        4: begin op = ($urandom_range(0, 1) == 0) ? 6'b000100 : 6'b000101; base = 3; end
        5: begin op = 6'b000010; base = 3; end
        default: begin op = 6'b001000 | 6'($urandom_range(0, 7)); base = 4; end
      endcase
      run_instr(op, fn, fw, mw, cyc, pcw_n, irw_n, tr);
      chk("rand_cycles", 32'(cyc), 32'(base + fw));
      $display("rand %0d: op=%b fn=%b fw=%0d mw=%0d cycles=%0d", n, op, fn, fw, mw, cyc);
    end

    // illegal opcode: TRAP with illegal held until reset
    opcode = 6'b111111; func = '0; mem_ready = 1;
    for (int k = 0; k < 10 && exp_state != S_TRAP; k++) next_cycle();
    illegal_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      if (illegal == 1'b1 && state == 4'(S_TRAP)) illegal_cnt++;
      next_cycle();
    end
    chk("trap_illegal_cycles", 32'(illegal_cnt), 32'd20);
    reset = 1;
    next_cycle();
    @(negedge clk);
    chk("trap_reset_illegal", 32'(illegal), 32'd0);
    chk("trap_reset_state", 32'(state), 32'd0);
    reset = 0;
    next_cycle();
    $display("illegal: held %0d cycles, cleared by reset", illegal_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
